// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE754 single-precision divider, result = A / B.
//
// Radix-2 restoring mantissa division behind a start/done handshake.
// Denormal operands are flushed to zero and the quotient is truncated.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while idle
//   A, B      dividend and divisor (fp32)
//   busy      high while unpacking, dividing or packing
//   done      one-cycle pulse; result and flags valid from this cycle on
//   result    quotient, held until the next accepted start
//   overflow  result exponent exceeded the largest finite exponent
//   underflow result exponent fell below the smallest normal exponent
//   dz        finite nonzero value divided by zero
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [EXP_W+MAN_W:0]     A,
  input  logic [EXP_W+MAN_W:0]     B,
  output logic                     busy,
  output logic                     done,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     dz
);

  localparam int FW = 1 + EXP_W + MAN_W;   // full word width
  localparam int MW = MAN_W + 1;           // mantissa incl. hidden bit
  localparam int QW = MAN_W + 2;           // quotient width
  localparam int EW = EXP_W + 2;           // signed exponent working width
  localparam int CW = $clog2(QW);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_PACK   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAXFIN = EW'((1 << EXP_W) - 2);
  localparam logic signed [EW-1:0] EMINFIN = EW'(1);

  localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [2:0]              state;
  logic [FW-1:0]           a_q;
  logic [FW-1:0]           b_q;
  logic                    sign_q;
  logic signed [EW-1:0]    exp_q;
  logic [MW:0]             rem_q;
  logic [MW-1:0]           mb_q;
  logic [QW-1:0]           q_q;
  logic [CW-1:0]           cnt_q;

  // Build the final word from the quotient: normalise by at most one
  // position (quotient lies in (0.5, 2)), truncate, then range-check.
  // Returns {overflow, underflow, word}.
  function automatic logic [FW+1:0] pack_result(
    input logic                 sign,
    input logic signed [EW-1:0] e,
    input logic [QW-1:0]        q
  );
    logic signed [EW-1:0] e_adj;
    logic [MAN_W-1:0]     mant;
    if (q[QW-1]) begin
      e_adj = e;
      mant  = q[QW-2:1];
    end else begin
      e_adj = e - EW'(1);
      mant  = q[QW-3:0];
    end
    if (e_adj > EMAXFIN)
      pack_result = {1'b1, 1'b0, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e_adj < EMINFIN)
      pack_result = {1'b0, 1'b1, sign, {(FW-1){1'b0}}};
    else
      pack_result = {1'b0, 1'b0, sign, e_adj[EXP_W-1:0], mant};
  endfunction

  // Operand classification on the latched operands
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_c;

  assign ea     = a_q[MAN_W +: EXP_W];
  assign eb     = b_q[MAN_W +: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign sign_c = a_q[FW-1] ^ b_q[FW-1];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  logic          special;
  logic          spec_dz;
  logic [FW-1:0] spec_word;

  always_comb begin
    special   = 1'b1;
    spec_dz   = 1'b0;
    spec_word = QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_word = QNAN;
    else if (a_inf)
      spec_word = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (b_zero) begin
      spec_word = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_dz   = 1'b1;
    end else if (a_zero || b_inf)
      spec_word = {sign_c, {(FW-1){1'b0}}};
    else
      special = 1'b0;
  end

  // One restoring step: compare, conditionally subtract, shift. After a
  // subtraction the remainder is below the divisor, so the top bit can be
  // dropped before shifting.
  logic          rem_ge;
  logic [MW:0]   rem_sub;
  logic [MW:0]   rem_next;
  logic [QW-1:0] q_next;

  assign rem_ge   = (rem_q >= {1'b0, mb_q});
  assign rem_sub  = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  assign rem_next = {rem_sub[MW-1:0], 1'b0};
  assign q_next   = {q_q[QW-2:0], rem_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      rem_q     <= '0;
      mb_q      <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q       <= A;
            b_q       <= B;
            busy      <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dz        <= 1'b0;
            state     <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= sign_c;
          if (special) begin
            result <= spec_word;
            dz     <= spec_dz;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
            rem_q <= {2'b01, fa};
            mb_q  <= {1'b1, fb};
            q_q   <= '0;
            cnt_q <= CW'(QW - 1);
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_next;
          q_q   <= q_next;
          if (cnt_q == '0)
            state <= S_PACK;
          else
            cnt_q <= cnt_q - CW'(1);
        end
        S_PACK: begin
          {overflow, underflow, result} <= pack_result(sign_q, exp_q, q_q);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, overflow, underflow, dz;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] r;
    logic        ov;
    logic        un;
    logic        dz;
    int          lat;
    int          st;
  } exp_t;

  exp_t sb[$];

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done && prev_done) chk("done_one_cycle", 32'd1, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
          chk("underflow", {31'd0, underflow}, {31'd0, e.un});
          chk("dz", {31'd0, dz}, {31'd0, e.dz});
          chk("latency", cyc - e.st, e.lat);
        end
      end
    end
    prev_done = done;
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic ov, input logic un,
                       input logic dzx, input int lat, input bit inject);
    exp_t e;
    int   busy_bad;
    bit   got;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    e.r = r; e.ov = ov; e.un = un; e.dz = dzx; e.lat = lat; e.st = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    busy_bad = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) busy_bad++;
      if (inject && i == 5) begin
        A = 32'h3F800000; B = 32'h3F800000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_low_while_working", busy_bad, 0);
    chk("done_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic quiet(input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("spurious_done", seen, 0);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {26'd0, busy, done, overflow, underflow, dz, |result}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {26'd0, busy, done, overflow, underflow, dz, |result}, 32'd0);

    // Normal operands
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27, 0);
    do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0, 0, 0, 27, 0);
    do_op(32'hC0E00000, 32'h40600000, 32'hC0000000, 0, 0, 0, 27, 0);

    // Special operands
    do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0, 1, 1, 0);
    do_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 0, 0, 1, 0);
    do_op(32'h00000000, 32'hC0000000, 32'h80000000, 0, 0, 0, 1, 0);
    do_op(32'hFF800001, 32'h3F800000, 32'h7FC00000, 0, 0, 0, 1, 0);
    do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 0, 0, 0, 1, 0);

    // Range limits
    do_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1, 0, 0, 27, 0);
    do_op(32'h00800000, 32'h40000000, 32'h00000000, 0, 1, 0, 27, 0);

    // Start pulsed during DIVIDE must be ignored
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 27, 1);
    quiet(40);
    chk("result_held", result, 32'h40400000);

    // Reset mid-operation
    @(negedge clk);
    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {26'd0, busy, done, overflow, underflow, dz, |result}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(40);
    do_op(32'hC0E00000, 32'h40600000, 32'hC0000000, 0, 0, 0, 27, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
